cache_fill_fsm: RTL
===================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, giving the byte-address width. It SHALL have no other parameters.
REQ-002 The block SHALL have the following ports, listed as name, direction, width, meaning:
  clk  input  1  single clock; all state updates occur on the rising edge.
  rst  input  1  asynchronous, active-high reset.
  miss_detected  input  1  the cache reports a miss on miss_address.
  miss_address  input  ADDR_WIDTH  byte address that missed; tag=[15:10], set=[9:4], offset=[3:0].
  memory_data_valid  input  1  memory_data holds one returned word this cycle.
  memory_data  input  16  word returned by memory.
  fsm_busy  output  1  a fill is in progress; the cache stalls.
  mem_en  output  1  memory read request this cycle.
  memory_address  output  ADDR_WIDTH  word-aligned address of the memory read request.
  write_data_array  output  1  write memory_data into the cache data array.
  cache_wr_addr  output  ADDR_WIDTH  cache address of the word being written; bit 0 is 0.
  cache_data_out  output  16  equal to memory_data (combinational pass-through).
  write_tag_array  output  1  one-cycle pulse that writes tag, valid, and LRU metadata for the filled block.

Function
REQ-003 The block SHALL fill one 16-byte block, which is 8 words at word index = address[3:1].
REQ-004 States SHALL be IDLE and FILL; the encoding is free.
REQ-005 In IDLE, if miss_detected=1, the block SHALL latch block base = {miss_address[15:4],4'b0} and the start index, and SHALL enter FILL on the next edge.
REQ-006 In IDLE, the block SHALL hold fsm_busy=0, mem_en=0, write_data_array=0, and write_tag_array=0.
REQ-007 In FILL, the block SHALL hold fsm_busy=1 and SHALL issue exactly 8 requests, one per cycle over 8 consecutive cycles, starting with the first FILL cycle.
REQ-008 Request k (k=0..7) SHALL use word index (start+k) mod 8. memory_address SHALL be base+2*index, with mem_en=1 during each request cycle and mem_en=0 afterwards.
REQ-009 In FILL, each cycle with memory_data_valid=1 SHALL assert write_data_array=1 in that same cycle. cache_wr_addr SHALL be base+2*((start+r) mod 8), where r = number of words already received (0..7). Responses arrive in request order.
REQ-010 The issue counter and the receive counter SHALL each be 4 bits wide and saturate at 8. The word index SHALL be 3 bits wide and wrap 7->0.
REQ-011 When the 8th word is received, the block SHALL assert write_tag_array=1 in that same cycle and SHALL return to IDLE on the next edge.
REQ-012 Memory latency is arbitrary (at least 1 cycle). A response MAY coincide with a later request cycle, and both SHALL be handled in that cycle.
REQ-013 miss_detected SHALL be ignored while in FILL; the latched base and start index SHALL NOT change.
REQ-014 memory_data_valid SHALL be ignored in IDLE, and also in FILL after 8 words have been received. In those cases the block SHALL raise no write strobe.
REQ-015 When miss_detected=1 in the cycle the block returns to IDLE, the miss SHALL be accepted one cycle later. The block SHALL therefore spend at least 1 cycle in IDLE between fills.

Reset
REQ-016 When rst=1, the block SHALL asynchronously force IDLE, clear both counters, base, and start index, and drive every output to 0 (cache_data_out still equals memory_data).
REQ-017 A reset in the middle of a fill SHALL abort that fill. No write_tag_array SHALL follow. After reset, late memory_data_valid pulses SHALL be ignored per REQ-014.

Configuration
REQ-018 With macro CACHE_FILL_CRITICAL_WORD_FIRST_EN defined, the start index SHALL be miss_address[3:1], so the missed word is fetched first and the index wraps. Without the macro, the start index SHALL be 0 and bits [3:1] SHALL be ignored.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
  (a) Macro off, miss at 0x1A36, 1-cycle memory: memory_address = 0x1A30, 0x1A32 ... 0x1A3E on 8 consecutive cycles; 8 write_data_array pulses; write_tag_array coincides with the 8th; fsm_busy drops the next cycle.
  (b) Macro on, miss at 0x1A36: request order 0x1A36, 0x1A38, 0x1A3A, 0x1A3C, 0x1A3E, 0x1A30, 0x1A32, 0x1A34; cache_wr_addr follows the same order.
  (c) 4-cycle memory with miss_detected held high throughout: exactly 8 requests; base does not change; the next fill starts after 1 IDLE cycle.
  (d) Reset asserted after the 3rd word: all outputs are 0 immediately; the 5 remaining valid pulses produce no write; no write_tag_array occurs.
  (e) memory_data_valid=1 in IDLE with memory_data=0xBEEF: write_data_array=0 and cache_data_out=0xBEEF.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fills one 16-byte (8-word) cache block after a miss.
// A miss latches the block base and a start word index, then the FILL
// state issues 8 word reads on consecutive cycles while writing each
// returned word into the data array. The 8th returned word also pulses
// write_tag_array, and the FSM returns to IDLE on the following edge.
//
// Optional feature macro: CACHE_FILL_CRITICAL_WORD_FIRST_EN
//   defined   -> start index = miss_address[3:1] (missed word first, wrapping)
//   undefined -> start index = 0 (block fetched in ascending order)
//
// Handshake: memory has no ready; mem_en=1 is a one-cycle read request
// for memory_address. memory_data_valid=1 marks one returned word in that
// cycle. Responses return in request order with at least one cycle of
// latency, and a response may share a cycle with a later request.

module cache_fill_fsm #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data,
  output logic                  fsm_busy,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  write_data_array,
  output logic [ADDR_WIDTH-1:0] cache_wr_addr,
  output logic [15:0]           cache_data_out,
  output logic                  write_tag_array
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-5:0]   base_blk;   // block address bits above the 16-byte offset
  logic [2:0]              start_idx;  // first word index of the fill
  logic [3:0]              issue_cnt;  // requests issued, saturates at 8
  logic [3:0]              recv_cnt;   // words received, saturates at 8
  logic [2:0]              req_idx;
  logic [2:0]              wr_idx;
  logic [2:0]              miss_start;
  logic                    unused_offset;

  // Start word chosen at miss time; byte-offset bit 0 never matters.
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  assign miss_start = miss_address[3:1];
`else
  assign miss_start = 3'd0;
`endif
  assign unused_offset = ^miss_address[3:0];

  // Word indices wrap naturally in 3 bits.
  assign req_idx = start_idx + issue_cnt[2:0];
  assign wr_idx  = start_idx + recv_cnt[2:0];

  assign cache_data_out = memory_data;

  // Next state and all strobes/addresses; idle values assigned first.
  always_comb begin
    state_next       = state;
    fsm_busy         = 1'b0;
    mem_en           = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    cache_wr_addr    = '0;
    write_tag_array  = 1'b0;
    case (state)
      IDLE: begin
        if (miss_detected) state_next = FILL;
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (issue_cnt < 4'd8) begin
          mem_en         = 1'b1;
          memory_address = {base_blk, req_idx, 1'b0};
        end
        if (memory_data_valid && (recv_cnt < 4'd8)) begin
          write_data_array = 1'b1;
          cache_wr_addr    = {base_blk, wr_idx, 1'b0};
          if (recv_cnt == 4'd7) begin
            write_tag_array = 1'b1;
            state_next      = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus miss latch and the two saturating counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base_blk  <= '0;
      start_idx <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base_blk  <= miss_address[ADDR_WIDTH-1:4];
            start_idx <= miss_start;
            issue_cnt <= '0;
            recv_cnt  <= '0;
          end
        end
        FILL: begin
          if (mem_en)           issue_cnt <= issue_cnt + 4'd1;
          if (write_data_array) recv_cnt  <= recv_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
